// File: rtl/booth_radix4_seq_multiplier.sv
// booth_radix4_seq_multiplier: iterative radix-4 Booth multiplier with valid/ready handshakes
module booth_radix4_seq_multiplier #(
  parameter int N = 32,
  localparam int ITER = N/2 + 1,
  localparam int CW = $clog2(ITER + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   inputA,
  input  logic [N-1:0]   inputB,
  input  logic           is_signed,
  output logic           busy,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] result
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [N+1:0] a_q, q;
  logic qm1;
  logic [N+3:0] acc, a4, pp, sum;
  logic [CW-1:0] cnt;
  logic [2:0] trip;
  logic accept, last;
  assign in_ready  = state == IDLE;
  assign busy      = state == BUSY;
  assign out_valid = state == DONE;
  always_comb begin
    accept = state == IDLE && in_valid;
    last = state == BUSY && cnt == CW'(1);
    state_nx = accept ? BUSY : last ? DONE : (state == DONE && out_ready) ? IDLE : state;
    a4 = {{2{a_q[N+1]}}, a_q};
    trip = {q[1:0], qm1};
    pp = (trip == 3'b001 || trip == 3'b010) ? a4 :
         trip == 3'b011 ? a4 << 1 :
         trip == 3'b100 ? -(a4 << 1) :
         (trip == 3'b101 || trip == 3'b110) ? -a4 : '0;
    sum = acc + pp;
  end
  // {acc, q, qm1} shifts right by 2 each step; the product's low 2N bits straddle acc and q
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      q <= '0;
      qm1 <= 1'b0;
      a_q <= '0;
      result <= '0;
    end else if (en) begin
      state <= state_nx;
      if (accept) begin
        a_q <= is_signed ? {{2{inputA[N-1]}}, inputA} : {2'b00, inputA};
        q <= is_signed ? {{2{inputB[N-1]}}, inputB} : {2'b00, inputB};
        qm1 <= 1'b0;
        acc <= '0;
        cnt <= CW'(ITER);
      end else if (state == BUSY) begin
        acc <= {{2{sum[N+3]}}, sum[N+3:2]};
        q <= {sum[1:0], q[N+1:2]};
        qm1 <= q[1];
        cnt <= cnt - CW'(1);
        if (last) result <= {sum[N-1:0], q[N+1:2]};
      end
    end
  end
endmodule

// File: tb/tb_booth_radix4_seq_multiplier.sv
// tb_booth_radix4_seq_multiplier: randomized self-checking bench against an arithmetic reference product
module tb_booth_radix4_seq_multiplier;
  logic clk = 0, reset = 1, en = 1, in_valid = 0, out_ready = 0, is_signed = 0;
  logic in_ready, busy, out_valid;
  logic [31:0] inputA = 0, inputB = 0;
  logic [63:0] result;
  int errors = 0, checks = 0;

  booth_radix4_seq_multiplier #(.N(32)) dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .inputA(inputA), .inputB(inputB), .is_signed(is_signed), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sb;
    sa = s ? {{32{a[31]}}, a} : {32'b0, a};
    sb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return sa * sb;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    inputA = a; inputB = b; is_signed = s; in_valid = 1; en = 1;
    checks++;
    if (in_ready !== 1) begin errors++; $display("FAIL accept_ready: in_ready=%b required 1", in_ready); end
    tick();
    in_valid = 0;
    checks++;
    if (busy !== 1) begin errors++; $display("FAIL accept_busy: busy=%b required 1", busy); end
  endtask

  task automatic wait_done(input bit scramble, output int lat, output int raw);
    lat = 0; raw = 0;
    while (out_valid !== 1 && raw < 200) begin
      if (scramble) begin
        en = ($urandom_range(0, 3) != 0);
        in_valid = $urandom_range(0, 1);
        inputA = $urandom; inputB = $urandom; is_signed = $urandom_range(0, 1);
      end
      tick();
      raw++;
      if (en) lat++;
    end
    en = 1; in_valid = 0;
    checks++;
    if (out_valid !== 1) begin errors++; $display("FAIL done_timeout: out_valid=%b required 1", out_valid); end
  endtask

  task automatic finish_op(input logic [63:0] exp, input bit scramble, input string name);
    int n = 0;
    while (out_valid === 1 && n < 100) begin
      checks++;
      if (result !== exp) begin errors++; $display("FAIL %s_result: got %h required %h", name, result, exp); end
      out_ready = scramble ? $urandom_range(0, 1) : 1;
      en = scramble ? ($urandom_range(0, 3) != 0) : 1;
      if (scramble) begin in_valid = $urandom_range(0, 1); inputA = $urandom; end
      tick();
      n++;
    end
    out_ready = 0; en = 1; in_valid = 0;
    checks++;
    if (in_ready !== 1 || out_valid !== 0 || result !== exp) begin
      errors++;
      $display("FAIL %s_release: in_ready=%b out_valid=%b result=%h required 1 0 %h", name, in_ready, out_valid, result, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    tick(); tick();
    reset = 0;
    checks++;
    if (in_ready !== 1 || out_valid !== 0 || busy !== 0 || result !== 0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b result=%h required 1 0 0 0", in_ready, out_valid, busy, result);
    end
  endtask

  task automatic test_directed();
    logic [31:0] av [3] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] bv [3] = '{32'd6, 32'h8000_0000, 32'hFFFF_FFFF};
    logic sv [3] = '{1'b1, 1'b1, 1'b0};
    logic [63:0] ev [3] = '{64'hFFFF_FFFF_FFFF_FFD6, 64'h4000_0000_0000_0000, 64'hFFFF_FFFE_0000_0001};
    int lat, raw;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ref_mul(av[i], bv[i], sv[i]) !== ev[i]) begin errors++; $display("FAIL model_%0d: got %h required %h", i, ref_mul(av[i], bv[i], sv[i]), ev[i]); end
      start_op(av[i], bv[i], sv[i]);
      wait_done(0, lat, raw);
      checks++;
      if (lat !== 17) begin errors++; $display("FAIL directed_latency_%0d: got %0d required 17", i, lat); end
      finish_op(ev[i], 0, "directed");
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp = ref_mul(32'd12345, 32'hFFFF_FFFD, 1);
    int lat, raw;
    start_op(32'd12345, 32'hFFFF_FFFD, 1);
    wait_done(0, lat, raw);
    in_valid = 1; inputA = 32'd99; inputB = 32'd77; is_signed = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (result !== exp || in_ready !== 0 || out_valid !== 1 || busy !== 0) begin
        errors++;
        $display("FAIL backpressure: result=%h in_ready=%b out_valid=%b busy=%b required %h 0 1 0", result, in_ready, out_valid, busy, exp);
      end
    end
    in_valid = 0;
    finish_op(exp, 0, "backpressure");
  endtask

  task automatic test_stall();
    int lat, raw;
    start_op(32'd1000, 32'd2000, 0);
    for (int i = 0; i < 5; i++) tick();
    en = 0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (busy !== 1 || out_valid !== 0) begin errors++; $display("FAIL stall_state: busy=%b out_valid=%b required 1 0", busy, out_valid); end
    en = 1;
    wait_done(0, lat, raw);
    checks++;
    if (raw + 8 !== 20) begin errors++; $display("FAIL stall_slip: valid after %0d cycles required 20", raw + 8); end
    finish_op(64'd2000000, 0, "stall");
  endtask

  task automatic test_reset_midop();
    int seen = 0, lat, raw;
    start_op(32'hDEAD_BEEF, 32'h1234_5678, 0);
    for (int i = 0; i < 7; i++) tick();
    reset = 1;
    tick();
    reset = 0;
    checks++;
    if (in_ready !== 1 || out_valid !== 0 || busy !== 0 || result !== 0) begin
      errors++;
      $display("FAIL midop_reset: in_ready=%b out_valid=%b busy=%b result=%h required 1 0 0 0", in_ready, out_valid, busy, result);
    end
    for (int i = 0; i < 20; i++) begin tick(); if (out_valid === 1) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midop_no_valid: out_valid cycles=%0d required 0", seen); end
    start_op(32'd3, 32'd5, 0);
    wait_done(0, lat, raw);
    finish_op(64'd15, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int lat, raw;
    start_op(32'd7, 32'd9, 0);
    wait_done(0, lat, raw);
    in_valid = 1; inputA = 32'hFFFF_FFFE; inputB = 32'd4; is_signed = 1; out_ready = 1;
    tick();
    checks++;
    if (in_ready !== 1 || busy !== 0 || result !== 64'd63) begin
      errors++;
      $display("FAIL b2b_handshake: in_ready=%b busy=%b result=%h required 1 0 %h", in_ready, busy, result, 64'd63);
    end
    out_ready = 0;
    tick();
    in_valid = 0;
    checks++;
    if (busy !== 1) begin errors++; $display("FAIL b2b_accept: busy=%b required 1", busy); end
    wait_done(0, lat, raw);
    checks++;
    if (lat !== 17) begin errors++; $display("FAIL b2b_latency: got %0d required 17", lat); end
    finish_op(64'hFFFF_FFFF_FFFF_FFF8, 0, "b2b");
  endtask

  task automatic test_random();
    logic [31:0] edge_v [4] = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [31:0] a, b;
    logic s;
    int lat, raw;
    for (int i = 0; i < 1500; i++) begin
      a = ($urandom_range(0, 7) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 7) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
      s = $urandom_range(0, 1);
      start_op(a, b, s);
      wait_done(1, lat, raw);
      checks++;
      if (lat !== 17) begin errors++; $display("FAIL random_latency: got %0d required 17 (op %0d)", lat, i); end
      finish_op(ref_mul(a, b, s), 1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_stall();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
